// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl
// Brief   : 5-stage pipeline valid/latch-enable sequencer with stall, branch
//           kill, exception flush and a stall watchdog. The optional macro
//           PIPE_HAZARD_PERF_EN adds stall-cycle and flush counters.
// Revision: 1.0
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int unsigned            REFILL_CYC    = 2,
    parameter int unsigned            STALL_CNT_W   = 16,
    parameter logic [STALL_CNT_W-1:0] STALL_TIMEOUT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_ready_i,
    input  logic        id_regs_read_ready_i,
    input  logic        id_branch_flush_i,
    input  logic        ex_busy_i,
    input  logic        mem_ready_i,
    input  logic        wb_excp_i,
    output logic        pc_we_o,
    output logic        id_we_o,
    output logic        ex_we_o,
    output logic        mem_we_o,
    output logic        wb_we_o,
    output logic        id_valid_o,
    output logic        ex_valid_o,
    output logic        mem_valid_o,
    output logic        wb_valid_o,
    output logic        excp_redirect_o,
    output logic        stall_timeout_o
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cyc_cnt_o,
    output logic [15:0] flush_cnt_o
`endif
);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    logic [0:0]             state, state_nxt;
    logic [3:0]             refill_cnt, refill_nxt;
    logic                   id_valid, ex_valid, mem_valid, wb_valid;
    logic                   excp_redirect, stall_timeout;
    logic [STALL_CNT_W-1:0] stall_cnt, stall_cnt_nxt;

    logic id_ready_go, ex_ready_go, mem_ready_go;
    logic id_allowin, ex_allowin, mem_allowin;
    logic branch_kill, excp, stalled;

    assign id_ready_go  = id_regs_read_ready_i;
    assign ex_ready_go  = ~ex_busy_i;
    assign mem_ready_go = mem_ready_i | ~mem_valid;

    // WB always accepts, so the allow-in chain starts at MEM.
    assign mem_allowin = ~mem_valid | mem_ready_go;
    assign ex_allowin  = ~ex_valid | (ex_ready_go & mem_allowin);
    assign id_allowin  = ~id_valid | (id_ready_go & ex_allowin);

    assign branch_kill = id_valid & id_ready_go & ex_allowin & id_branch_flush_i;
    assign excp        = wb_valid & wb_excp_i;
    assign stalled     = (id_valid & ~id_ready_go) | (ex_valid & ~ex_ready_go)
                       | (mem_valid & ~mem_ready_go);

    assign ex_we_o  = ex_allowin & id_valid & id_ready_go;
    assign mem_we_o = mem_allowin & ex_valid & ex_ready_go;
    assign wb_we_o  = mem_valid & mem_ready_go;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_RUN;
            refill_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            refill_cnt <= refill_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        refill_nxt = refill_cnt;
        case (state)
            S_RUN: begin
                if (excp) begin
                    state_nxt  = S_FLUSH;
                    refill_nxt = 4'(REFILL_CYC);
                end
            end
            S_FLUSH: begin
                refill_nxt = refill_cnt - 4'd1;
                if (refill_cnt == 4'd1) begin
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_RUN;
        endcase
    end

    // Fetch side is only open in S_RUN; a branch kill drops the IF instruction.
    always_comb begin
        pc_we_o = 1'b0;
        id_we_o = 1'b0;
        case (state)
            S_RUN: begin
                pc_we_o = id_allowin & if_ready_i;
                id_we_o = id_allowin & if_ready_i & ~branch_kill;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid      <= 1'b0;
            ex_valid      <= 1'b0;
            mem_valid     <= 1'b0;
            wb_valid      <= 1'b0;
            excp_redirect <= 1'b0;
        end else begin
            excp_redirect <= excp;
            if (excp) begin
                id_valid  <= 1'b0;
                ex_valid  <= 1'b0;
                mem_valid <= 1'b0;
                wb_valid  <= 1'b0;
            end else begin
                if (id_allowin)  id_valid  <= id_we_o;
                if (ex_allowin)  ex_valid  <= id_valid & id_ready_go;
                if (mem_allowin) mem_valid <= ex_valid & ex_ready_go;
                wb_valid <= mem_valid & mem_ready_go;
            end
        end
    end

    always_comb begin
        stall_cnt_nxt = '0;
        if ((state == S_RUN) && stalled) begin
            stall_cnt_nxt = (&stall_cnt) ? stall_cnt : stall_cnt + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt     <= '0;
            stall_timeout <= 1'b0;
        end else begin
            stall_cnt     <= stall_cnt_nxt;
            stall_timeout <= stall_timeout | (stall_cnt_nxt == STALL_TIMEOUT);
        end
    end

    assign id_valid_o      = id_valid;
    assign ex_valid_o      = ex_valid;
    assign mem_valid_o     = mem_valid;
    assign wb_valid_o      = wb_valid;
    assign excp_redirect_o = excp_redirect;
    assign stall_timeout_o = stall_timeout;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cyc_cnt;
    logic [15:0] flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cyc_cnt <= 32'd0;
            flush_cnt     <= 16'd0;
        end else begin
            if ((state == S_RUN) && !pc_we_o) stall_cyc_cnt <= stall_cyc_cnt + 32'd1;
            if (excp | branch_kill)           flush_cnt     <= flush_cnt + 16'd1;
        end
    end

    assign stall_cyc_cnt_o = stall_cyc_cnt;
    assign flush_cnt_o     = flush_cnt;
`else
    // Performance counters are absent in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_hazard_ctrl
// Brief   : Directed plus random stimulus for pipe_hazard_ctrl against a
//           slot-moving pipeline reference model.
// Revision: 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int unsigned REFILL = 2;
    localparam int unsigned TMO    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic if_ready_i = 1'b0, id_regs_read_ready_i = 1'b1, id_branch_flush_i = 1'b0;
    logic ex_busy_i = 1'b0, mem_ready_i = 1'b1, wb_excp_i = 1'b0;
    logic pc_we_o, id_we_o, ex_we_o, mem_we_o, wb_we_o;
    logic id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o;
    logic excp_redirect_o, stall_timeout_o;

    int errors = 0;
    int checks = 0;

    // Reference state: slot occupancy ID..WB plus control flags.
    bit mv [4];
    bit mflush, mredir, mtmo;
    int mrefill, mscnt;

    pipe_hazard_ctrl #(
        .REFILL_CYC   (REFILL),
        .STALL_CNT_W  (16),
        .STALL_TIMEOUT(16'(TMO))
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .if_ready_i          (if_ready_i),
        .id_regs_read_ready_i(id_regs_read_ready_i),
        .id_branch_flush_i   (id_branch_flush_i),
        .ex_busy_i           (ex_busy_i),
        .mem_ready_i         (mem_ready_i),
        .wb_excp_i           (wb_excp_i),
        .pc_we_o             (pc_we_o),
        .id_we_o             (id_we_o),
        .ex_we_o             (ex_we_o),
        .mem_we_o            (mem_we_o),
        .wb_we_o             (wb_we_o),
        .id_valid_o          (id_valid_o),
        .ex_valid_o          (ex_valid_o),
        .mem_valid_o         (mem_valid_o),
        .wb_valid_o          (wb_valid_o),
        .excp_redirect_o     (excp_redirect_o),
        .stall_timeout_o     (stall_timeout_o)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] outs();
        return {pc_we_o, id_we_o, ex_we_o, mem_we_o, wb_we_o,
                id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o,
                excp_redirect_o, stall_timeout_o};
    endfunction

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) mv[k] = 1'b0;
        mflush = 1'b0; mredir = 1'b0; mtmo = 1'b0;
        mrefill = 0; mscnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        if_ready_i = 1'b0; id_regs_read_ready_i = 1'b1; id_branch_flush_i = 1'b0;
        ex_busy_i = 1'b0; mem_ready_i = 1'b1; wb_excp_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("reset", outs(), 11'b0);
    endtask

    // One clock: drive inputs, predict and compare at negedge, advance model after posedge.
    task automatic step(input bit ifr, input bit rr, input bit bf,
                        input bit eb, input bit mr, input bit ex);
        bit go [4];
        bit nv [4];
        bit we [4];
        bit room, pc, kill, run, stalled;
        logic [10:0] exp;
        if_ready_i = ifr; id_regs_read_ready_i = rr; id_branch_flush_i = bf;
        ex_busy_i = eb; mem_ready_i = mr; wb_excp_i = ex;
        @(negedge clk);
        go[0] = rr; go[1] = !eb; go[2] = mr; go[3] = 1'b1;
        run = !mflush;
        for (int k = 0; k < 4; k++) begin nv[k] = 1'b0; we[k] = 1'b0; end
        kill = 1'b0;
        room = 1'b1;
        // Walk downstream to upstream; an instruction moves only into a slot that frees up.
        for (int k = 3; k >= 0; k--) begin
            if (mv[k] && go[k] && room) begin
                if (k < 3) begin nv[k+1] = 1'b1; we[k+1] = 1'b1; end
                if (k == 0 && bf) kill = 1'b1;
                room = 1'b1;
            end else if (mv[k]) begin
                nv[k] = 1'b1;
                room = 1'b0;
            end else begin
                room = 1'b1;
            end
        end
        pc = room && ifr && run;
        if (pc && !kill) begin nv[0] = 1'b1; we[0] = 1'b1; end
        exp = {pc, we[0], we[1], we[2], we[3], mv[0], mv[1], mv[2], mv[3], mredir, mtmo};
        chk("cycle", outs(), exp);

        stalled = (mv[0] && !rr) || (mv[1] && eb) || (mv[2] && !mr);
        @(posedge clk);
        #1;
        mscnt = (run && stalled) ? ((mscnt == 65535) ? mscnt : mscnt + 1) : 0;
        if (mscnt == TMO) mtmo = 1'b1;
        if (mv[3] && ex) begin
            for (int k = 0; k < 4; k++) nv[k] = 1'b0;
            mredir = 1'b1; mflush = 1'b1; mrefill = REFILL;
        end else begin
            mredir = 1'b0;
            if (mflush) begin
                mrefill--;
                if (mrefill == 0) mflush = 1'b0;
            end
        end
        for (int k = 0; k < 4; k++) mv[k] = nv[k];
    endtask

    initial begin
        do_reset();

        // Fill: valids appear one stage per cycle.
        step(1, 1, 0, 0, 1, 0);
        chk("fill1", {7'b0, id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o}, 11'b0000000_1000);
        repeat (3) step(1, 1, 0, 0, 1, 0);
        chk("fill4", {7'b0, id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o}, 11'b0000000_1111);
        repeat (2) step(1, 1, 0, 0, 1, 0);

        // Load-use for one cycle.
        step(1, 0, 0, 0, 1, 0);
        chk("loaduse_bubble", {10'b0, ex_valid_o}, 11'b0);
        repeat (3) step(1, 1, 0, 0, 1, 0);

        // Multi-cycle EX.
        repeat (5) step(1, 1, 0, 1, 1, 0);
        chk("exbusy_mem_empty", {10'b0, mem_valid_o}, 11'b0);
        repeat (3) step(1, 1, 0, 0, 1, 0);

        // Branch kill.
        step(1, 1, 1, 0, 1, 0);
        chk("kill_id", {10'b0, id_valid_o}, 11'b0);
        step(1, 1, 0, 0, 1, 0);
        chk("kill_refill", {10'b0, id_valid_o}, 11'b1);
        repeat (3) step(1, 1, 0, 0, 1, 0);

        // Exception at WB with refill settling.
        step(1, 1, 0, 0, 1, 1);
        chk("excp_t1", {pc_we_o, id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o,
                        excp_redirect_o, 5'b0}, 11'b000001_00000);
        repeat (2) step(1, 1, 0, 0, 1, 0);
        chk("excp_t3_pc", {10'b0, pc_we_o}, 11'b1);
        repeat (5) step(1, 1, 0, 0, 1, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 9) < 1, $urandom_range(0, 9) < 2,
                 $urandom_range(0, 9) < 8, $urandom_range(0, 19) < 1);
        end

        // Watchdog: MEM held waiting.
        do_reset();
        repeat (4) step(1, 1, 0, 0, 1, 0);
        repeat (3) step(1, 1, 0, 0, 0, 0);
        chk("tmo_before", {10'b0, stall_timeout_o}, 11'b0);
        step(1, 1, 0, 0, 0, 0);
        chk("tmo_set", {10'b0, stall_timeout_o}, 11'b1);
        repeat (2) step(1, 1, 0, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0, 1, 0);
        chk("tmo_sticky", {10'b0, stall_timeout_o}, 11'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
